// File: rtl/dsp_cic_pkg.sv
// -----------------------------------------------------------------------------
// dsp_cic_pkg
// Shared definitions for the CIC decimator run-time controller:
//   - cic_ctrl_state_e : controller state encoding (IDLE/FLUSH/SETTLE/RUN)
//   - CIC_N, CIC_M     : default CIC stage count and differential delay
//   - SETTLE_CNT       : default settle length (N*M discarded samples)
//   - sat_signed()     : clamp a 64-bit signed value to a w-bit signed range
// -----------------------------------------------------------------------------
package dsp_cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } cic_ctrl_state_e;

    localparam int CIC_N      = 5;
    localparam int CIC_M      = 1;
    localparam int SETTLE_CNT = CIC_N * CIC_M;

    // Result is still 64 bits wide; the caller keeps the low w bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/dsp_sync_fifo.sv
// -----------------------------------------------------------------------------
// dsp_sync_fifo
// Single-clock show-ahead FIFO. The head entry is visible on rd_data whenever
// empty=0; rd_data reads 0 while empty. A write while full is ignored, even if
// a read happens in the same cycle. flush empties the FIFO synchronously and
// takes priority over reads and writes.
// Parameters: WIDTH (data width), DEPTH (entries, power of 2, >= 2)
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : synchronous empty request
//   wr_en, wr_data  : write port
//   rd_en, rd_data  : read (pop) request, head data
//   full, empty     : occupancy flags
// -----------------------------------------------------------------------------
module dsp_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_wr    = wr_en & ~full;
    assign w_rd    = rd_en & ~empty;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only observable after
    // being written, so resetting it would only cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (w_wr && !flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/dsp_cic_dec_ctrl.sv
// -----------------------------------------------------------------------------
// dsp_cic_dec_ctrl
// Run-time controller wrapped around a CIC decimator: generates the decimation
// strobe, clears the datapath on start/reconfiguration, discards the N*M-sample
// settling transient, scales the full-precision output to COUT bits with
// saturation and buffers it behind a valid/ready stream.
// Build option: define DSP_CIC_CTRL_ROUND_EN to round half up before the shift;
// otherwise the shift truncates.
// Reset defaults for configuration: rate = 2, shift = 0.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   enable                        : run request
//   cfg_valid/cfg_ready           : configuration handshake
//   cfg_rate, cfg_shift           : decimation factor, output right-shift
//   din_vld                       : input sample enters the CIC
//   cic_clr, cic_dec_stb          : datapath clear, decimation strobe
//   cic_dout, cic_dvld            : CIC full-precision output and valid
//   m_tdata, m_tvalid, m_tready   : output stream
//   busy                          : state is not RUN
//   overflow                      : sticky sample-dropped flag
// -----------------------------------------------------------------------------
module dsp_cic_dec_ctrl
    import dsp_cic_pkg::*;
#(
    parameter int BOUT       = 38,
    parameter int COUT       = 16,
    parameter int N          = CIC_N,
    parameter int M          = CIC_M,
    parameter int RW         = 16,
    parameter int SW         = 6,
    parameter int CLR_CYC    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [RW-1:0]   cfg_rate,
    input  logic [SW-1:0]   cfg_shift,
    input  logic            din_vld,
    output logic            cic_clr,
    output logic            cic_dec_stb,
    input  logic [BOUT-1:0] cic_dout,
    input  logic            cic_dvld,
    output logic [COUT-1:0] m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            busy,
    output logic            overflow
);

    localparam int L_SETTLE    = N * M;
    localparam int L_MAX_SHIFT = BOUT - COUT;
    localparam int CCW         = $clog2(CLR_CYC + 1);
    localparam int SCW         = $clog2(L_SETTLE + 1);

    cic_ctrl_state_e    r_state;
    cic_ctrl_state_e    w_state_nxt;
    logic [RW-1:0]      r_rate;
    logic [RW-1:0]      r_rate_cnt;
    logic [SW-1:0]      r_shift;
    logic [CCW-1:0]     r_clr_cnt;
    logic [SCW-1:0]     r_settle_cnt;
    logic               r_sc_vld;
    logic [COUT-1:0]    r_sc_data;
    logic               r_overflow;
    logic               w_cfg_acc;
    logic               w_flush;
    logic               w_cic_run;
    logic               w_full;
    logic               w_empty;
    logic               w_take;
    logic signed [63:0] w_ext;
    logic signed [63:0] w_shr;
    logic [COUT-1:0]    w_scaled;

    assign w_cfg_acc   = cfg_valid & (r_state != ST_FLUSH);
    assign w_flush     = (r_state == ST_FLUSH);
    assign w_cic_run   = (r_state == ST_SETTLE) || (r_state == ST_RUN);
    assign w_take      = cic_dvld & (r_state == ST_RUN);
    assign cic_dec_stb = w_cic_run & din_vld & (r_rate_cnt == r_rate - RW'(1));
    assign m_tvalid    = ~w_empty;
    assign overflow    = r_overflow;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        cic_clr     = 1'b0;
        cfg_ready   = 1'b1;
        busy        = 1'b1;
        unique case (r_state)
            ST_IDLE:   cic_clr = 1'b1;
            ST_FLUSH: begin
                cic_clr   = 1'b1;
                cfg_ready = 1'b0;
            end
            ST_SETTLE: ;
            ST_RUN:    busy = 1'b0;
            default:   ;
        endcase

        // enable low wins over everything; a reconfig restarts the flush.
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else if (w_cfg_acc) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            unique case (r_state)
                ST_IDLE:   w_state_nxt = ST_FLUSH;
                ST_FLUSH:  if (r_clr_cnt == CCW'(CLR_CYC - 1)) w_state_nxt = ST_SETTLE;
                ST_SETTLE: if (cic_dvld && (r_settle_cnt == SCW'(L_SETTLE - 1)))
                               w_state_nxt = ST_RUN;
                ST_RUN:    w_state_nxt = ST_RUN;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Scaling: sign-extend, optional half-up rounding, arithmetic shift, clamp.
    always_comb begin
        w_ext = {{(64-BOUT){cic_dout[BOUT-1]}}, cic_dout};
`ifdef DSP_CIC_CTRL_ROUND_EN
        if (r_shift != '0) begin
            w_ext = w_ext + (64'sd1 <<< (r_shift - SW'(1)));
        end
`endif
        w_shr    = w_ext >>> r_shift;
        w_scaled = COUT'(sat_signed(w_shr, COUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush and settle counters only run inside their own state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt    <= '0;
            r_settle_cnt <= '0;
            r_rate_cnt   <= '0;
        end else begin
            r_clr_cnt <= w_flush ? r_clr_cnt + CCW'(1) : '0;
            if (r_state != ST_SETTLE) begin
                r_settle_cnt <= '0;
            end else if (cic_dvld) begin
                r_settle_cnt <= r_settle_cnt + SCW'(1);
            end
            if (!w_cic_run) begin
                r_rate_cnt <= '0;
            end else if (din_vld) begin
                r_rate_cnt <= cic_dec_stb ? '0 : r_rate_cnt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rate     <= RW'(2);
            r_shift    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_cfg_acc) begin
                r_rate  <= (cfg_rate < RW'(2)) ? RW'(2) : cfg_rate;
                r_shift <= (cfg_shift > SW'(L_MAX_SHIFT)) ? SW'(L_MAX_SHIFT) : cfg_shift;
            end
            // A drop in the reconfig cycle belongs to the old setup; clear wins.
            if (w_cfg_acc) begin
                r_overflow <= 1'b0;
            end else if (r_sc_vld && w_full && !w_flush) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sc_vld  <= 1'b0;
            r_sc_data <= '0;
        end else if (w_flush) begin
            r_sc_vld  <= 1'b0;
            r_sc_data <= '0;
        end else begin
            r_sc_vld <= w_take;
            if (w_take) begin
                r_sc_data <= w_scaled;
            end
        end
    end

    dsp_sync_fifo #(
        .WIDTH (COUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (w_flush),
        .wr_en   (r_sc_vld),
        .wr_data (r_sc_data),
        .rd_en   (m_tready),
        .rd_data (m_tdata),
        .full    (w_full),
        .empty   (w_empty)
    );

endmodule
